// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA engine.
package dma_pkg;

    localparam int unsigned WORD_SIZE_DEFAULT   = 16;
    localparam int unsigned FETCH_SIZE_DEFAULT  = 64;
    localparam int unsigned DMA_LEN_DEFAULT     = 12;
    localparam int unsigned MEM_LATENCY_DEFAULT = 4;
    localparam int unsigned DMA_BURST_WORDS     = 4;
    localparam int unsigned DMA_BURSTS          = DMA_LEN_DEFAULT / DMA_BURST_WORDS;
    localparam int unsigned CNT_W               = 4;
    localparam int unsigned IDX_W               = 2;

    localparam logic [15:0] DMA_BASE_DEFAULT = 16'h01F4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_XFER = 3'd2,
        ST_DONE = 3'd3,
        ST_WAIT = 3'd4
    } dma_state_e;

    // Destination word address of a burst; wraps at 16 bits.
    function automatic logic [15:0] burst_addr(input logic [15:0] base, input logic [IDX_W-1:0] burst);
        return base + {12'd0, burst, 2'b00};
    endfunction

endpackage

// File: rtl/dma_xfer_counter.sv
// Transfer cycle counter: advances while enabled, freezes otherwise, clears on request.
module dma_xfer_counter
    import dma_pkg::*;
#(
    parameter int unsigned LEN     = DMA_LEN_DEFAULT,
    parameter int unsigned LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] burst_c,
    output logic [CNT_W-1:0] offset_c,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Decode burst index, offset within burst and final cycle from the count.
    always_comb begin
        last_c   = (cnt_q == CNT_W'(LEN - 1));
        burst_c  = IDX_W'(cnt_q / CNT_W'(LATENCY));
        offset_c = cnt_q % CNT_W'(LATENCY);
    end

    // Next count: clear dominates, wrap to zero after the last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA: copies a 12-word device buffer to data memory in 4-word bursts.
// Optional build macro DMA_QUEUE_EN: remember one start request seen while busy.
module dma_controller
    import dma_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = WORD_SIZE_DEFAULT,
    parameter int unsigned FETCH_SIZE  = FETCH_SIZE_DEFAULT,
    parameter logic [15:0] DMA_BASE    = DMA_BASE_DEFAULT,
    parameter int unsigned DMA_LEN     = DMA_LEN_DEFAULT,
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  cmd,
    input  logic                  BG,
    output logic                  BR,
    output logic                  dma_end,
    inout  wire  [WORD_SIZE-1:0]  d_address,
    inout  wire                   d_writeM,
    inout  wire                   d_readM,
    inout  wire  [FETCH_SIZE-1:0] d_data,
    output logic [IDX_W-1:0]      dev_idx,
    input  logic [FETCH_SIZE-1:0] dev_data
);

    dma_state_e       state_q, state_d;
    logic             br_q, br_d;
    logic             dma_end_q, dma_end_d;
    logic [IDX_W-1:0] dev_idx_q, dev_idx_d;
    logic             own_c;
    logic             cnt_clr_c;
    logic [IDX_W-1:0] burst_c;
    logic [CNT_W-1:0] offset_c;
    logic             last_c;
    logic             burst_end_c;
    logic [15:0]      addr_c;
`ifdef DMA_QUEUE_EN
    logic             pending_q, pending_d;
`endif

    // Bus ownership is decoded combinationally so a falling BG releases the bus at once.
    always_comb begin
        own_c       = (state_q == ST_XFER) && BG;
        cnt_clr_c   = (state_q != ST_XFER);
        burst_end_c = (offset_c == CNT_W'(MEM_LATENCY - 1));
        addr_c      = burst_addr(DMA_BASE, burst_c);
    end

    dma_xfer_counter #(
        .LEN     (DMA_LEN),
        .LATENCY (MEM_LATENCY)
    ) u_cnt (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .clr      (cnt_clr_c),
        .en       (own_c),
        .burst_c  (burst_c),
        .offset_c (offset_c),
        .last_c   (last_c)
    );

    // Next state, pending request and registered output values.
    always_comb begin
        state_d   = state_q;
        dev_idx_d = dev_idx_q;
`ifdef DMA_QUEUE_EN
        pending_d = pending_q;
        if (cmd && (state_q != ST_IDLE) && !pending_q) begin
            pending_d = 1'b1;
        end
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef DMA_QUEUE_EN
                if (cmd || pending_q) begin
                    state_d   = ST_REQ;
                    pending_d = 1'b0;
                end
`else
                if (cmd) state_d = ST_REQ;
`endif
            end
            ST_REQ:  if (BG) state_d = ST_XFER;
            ST_XFER: if (own_c && last_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!BG) begin
                    state_d = ST_IDLE;
`ifdef DMA_QUEUE_EN
                    if (pending_q) begin
                        state_d   = ST_REQ;
                        pending_d = 1'b0;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Device index tracks the burst the counter will present next cycle.
        if (state_q != ST_XFER) begin
            dev_idx_d = '0;
        end else if (own_c && burst_end_c) begin
            dev_idx_d = last_c ? '0 : dev_idx_q + IDX_W'(1);
        end

        br_d      = (state_d == ST_REQ) || (state_d == ST_XFER);
        dma_end_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q   <= ST_IDLE;
            br_q      <= 1'b0;
            dma_end_q <= 1'b0;
            dev_idx_q <= '0;
`ifdef DMA_QUEUE_EN
            pending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            dma_end_q <= dma_end_d;
            dev_idx_q <= dev_idx_d;
`ifdef DMA_QUEUE_EN
            pending_q <= pending_d;
`endif
        end
    end

    assign BR        = br_q;
    assign dma_end   = dma_end_q;
    assign dev_idx   = dev_idx_q;
    assign d_address = own_c ? WORD_SIZE'(addr_c) : {WORD_SIZE{1'bz}};
    assign d_writeM  = own_c ? 1'b1 : 1'bz;
    assign d_readM   = own_c ? 1'b0 : 1'bz;
    assign d_data    = own_c ? dev_data : {FETCH_SIZE{1'bz}};

endmodule

// File: tb/tb_dma_controller.sv
// Directed plus randomized bench for dma_controller against a transfer-level model.
module tb_dma_controller;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        cmd;
    logic        BG;
    logic        BR;
    logic        dma_end;
    wire  [15:0] d_address;
    wire         d_writeM;
    wire         d_readM;
    wire  [63:0] d_data;
    logic [1:0]  dev_idx;
    logic [63:0] dev_data;

    logic [63:0] blk [3];

    int vectors     = 0;
    int miscompares = 0;

    // Model of the transfer: granted flag, words driven so far, pending request.
    bit m_br, m_xfer, m_end, m_wait, m_pend;
    int k;
    int m_ends, obs_ends;
    bit prev_br;
    int gap_left;
    bit gap_done, cmd_done;

    dma_controller dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .cmd       (cmd),
        .BG        (BG),
        .BR        (BR),
        .dma_end   (dma_end),
        .d_address (d_address),
        .d_writeM  (d_writeM),
        .d_readM   (d_readM),
        .d_data    (d_data),
        .dev_idx   (dev_idx),
        .dev_data  (dev_data)
    );

    initial forever #5 Clk = ~Clk;

    always_comb dev_data = (dev_idx != 2'd3) ? blk[dev_idx] : 64'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic model_reset();
        m_br = 0; m_xfer = 0; m_end = 0; m_wait = 0; m_pend = 0;
        k = 0; prev_br = 0;
    endtask

    task automatic chk_floating(input string tag);
        logic [15:0] za;
        logic [63:0] zd;
        za = 'z;
        zd = 'z;
        chk({tag, "_addr"}, 64'(d_address), 64'(za));
        chk({tag, "_wr"}, 64'(d_writeM), 64'(1'bz));
        chk({tag, "_rd"}, 64'(d_readM), 64'(1'bz));
        chk({tag, "_data"}, d_data, zd);
    endtask

    // One clock: apply inputs, compare mid-cycle, then advance the model over the edge.
    task automatic cycle(input bit c, input bit g);
        bit drv, idle, cap, e_next;
        logic [15:0] ea;
        @(posedge Clk);
        #1;
        cmd = c;
        BG  = g;
        @(negedge Clk);
        drv = m_xfer && g;
        chk("br", 64'(BR), 64'(m_br));
        chk("dma_end", 64'(dma_end), 64'(m_end));
        chk("dev_idx", 64'(dev_idx), 64'(k / 4));
        if (dma_end === 1'b1) obs_ends++;
        if (drv) begin
            ea = 16'h01F4 + 16'(4 * (k / 4));
            chk("addr", 64'(d_address), 64'(ea));
            chk("wr", 64'(d_writeM), 64'(1'b1));
            chk("rd", 64'(d_readM), 64'(1'b0));
            chk("data", d_data, blk[k / 4]);
        end else begin
            chk_floating("idle_bus");
        end
        prev_br = m_br;
        idle    = !m_br && !m_end && !m_wait;
        cap     = 1'b0;
`ifdef DMA_QUEUE_EN
        cap = c && !idle && !m_pend;
`endif
        e_next = 1'b0;
        if (m_xfer) begin
            if (g) begin
                k++;
                if (k == 12) begin
                    k = 0; m_xfer = 0; m_br = 0; e_next = 1; m_ends++;
                end
            end
        end else if (m_br) begin
            if (g) m_xfer = 1;
        end else if (m_end) begin
            m_wait = 1;
        end else if (m_wait) begin
            if (!g) begin
                m_wait = 0;
                if (m_pend) begin m_br = 1; m_pend = 0; end
            end
        end else if (c || m_pend) begin
            m_br = 1; m_pend = 0;
        end
        if (cap) m_pend = 1;
        m_end = e_next;
    endtask

    // Grant follows request one cycle late; optional grant gap and mid-transfer cmd.
    task automatic auto(input int n, input int gap_k, input int gap_len, input int cmd_k);
        bit c, g;
        gap_left = 0; gap_done = 0; cmd_done = 0;
        for (int i = 0; i < n; i++) begin
            g = prev_br;
            if (gap_len > 0 && !gap_done && m_xfer && k == gap_k) begin
                gap_left = gap_len; gap_done = 1;
            end
            if (gap_left > 0) begin g = 0; gap_left--; end
            c = 0;
            if (cmd_k >= 0 && !cmd_done && m_xfer && k == cmd_k) begin c = 1; cmd_done = 1; end
            cycle(c, g);
        end
    endtask

    task automatic rand_blocks();
        for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom};
    endtask

    initial begin
        int budget;
        model_reset();
        m_ends = 0; obs_ends = 0;
        Reset_N = 0; cmd = 0; BG = 0;
        blk[0] = 64'h1111_1111_1111_1111;
        blk[1] = 64'h2222_2222_2222_2222;
        blk[2] = 64'h3333_3333_3333_3333;
        #12;
        chk("rst_br", 64'(BR), 64'd0);
        chk("rst_end", 64'(dma_end), 64'd0);
        chk("rst_idx", 64'(dev_idx), 64'd0);
        chk_floating("rst_bus");
        @(negedge Clk);
        Reset_N = 1;

        // Basic transfer with fixed blocks.
        cycle(1, 0);
        auto(30, -1, 0, -1);

        // Grant withdrawn for three cycles at count 5.
        rand_blocks();
        cycle(1, 0);
        auto(35, 5, 3, -1);

        // Reset asserted mid-transfer at count 7.
        rand_blocks();
        cycle(1, 0);
        budget = 0;
        while (!(m_xfer && k == 7) && budget < 40) begin
            auto(1, -1, 0, -1);
            budget++;
        end
        if (budget >= 40) timeout("reach_cnt7");
        @(posedge Clk);
        #1;
        cmd = 0; BG = 1;
        #2;
        Reset_N = 0;
        #1;
        chk("abort_br", 64'(BR), 64'd0);
        chk("abort_end", 64'(dma_end), 64'd0);
        chk("abort_idx", 64'(dev_idx), 64'd0);
        chk_floating("abort_bus");
        @(negedge Clk);
        @(negedge Clk);
        Reset_N = 1;
        BG = 0;
        model_reset();

        // Restart after abort begins at the base address.
        cycle(1, 0);
        auto(30, -1, 0, -1);

        // Start request repeated during the transfer.
        rand_blocks();
        cycle(1, 0);
        auto(70, -1, 0, 3);

        // cmd and BG high together in IDLE.
        rand_blocks();
        cycle(1, 1);
        auto(30, -1, 0, -1);

        // Randomized transfers with random grant gaps.
        for (int t = 0; t < 4; t++) begin
            rand_blocks();
            cycle(1, 0);
            auto(50, int'($urandom_range(0, 11)), int'($urandom_range(0, 4)), -1);
        end

        chk("end_total", 64'(obs_ends), 64'(m_ends));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
